// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the FIFO and its serial drain stage.
// The master (drain) pops bytes; the slave (FIFO) reports occupancy and data.
interface fifo_uart_tx_if;
   logic       read;
   logic       f_empty_n;
   logic [7:0] fifo_data;

   modport master (
      output read,
      input  f_empty_n,
      input  fifo_data
   );

   modport slave (
      input  read,
      output f_empty_n,
      output fifo_data
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as an 8N1 frame on tx_o.
// Frames run back-to-back while the FIFO is non-empty and enable_i is high.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  tx_done_o,
   output logic [7:0]            byte_cnt_o
);

   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StStart, StData, StStop} state_e;

   localparam logic [CNT_W-1:0] BaudMax = CNT_W'(CLKS_PER_BIT - 1);

   state_e           state_q;
   logic             read_q;
   logic             tx_q;
   logic             tx_done_q;
   logic [7:0]       byte_cnt_q;
   logic [7:0]       shift_q;
   logic [CNT_W-1:0] baud_q;
   logic [2:0]       bit_q;
   logic             baud_end;

   assign baud_end = (baud_q == BaudMax);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         read_q     <= 1'b0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
         byte_cnt_q <= 8'd0;
         shift_q    <= 8'd0;
         baud_q     <= '0;
         bit_q      <= 3'd0;
      end else begin
         tx_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (enable_i && fifo.f_empty_n) begin
                  read_q  <= 1'b1;
                  state_q <= StFetch;
               end
            end
            StFetch: begin
               read_q  <= 1'b0;
               state_q <= StLoad;
            end
            // FIFO data is valid here, one cycle after the pop was sampled.
            StLoad: begin
               shift_q <= fifo.fifo_data;
               tx_q    <= 1'b0;
               baud_q  <= '0;
               state_q <= StStart;
            end
            StStart: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  tx_q    <= shift_q[0];
                  bit_q   <= 3'd0;
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            StData: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q != 3'd7) begin
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 3'd1;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            StStop: begin
               if (baud_end) begin
                  baud_q     <= '0;
                  tx_done_q  <= 1'b1;
                  byte_cnt_q <= byte_cnt_q + 8'd1;
                  state_q    <= StIdle;
               end else begin
                  baud_q <= baud_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign fifo.read  = read_q;
   assign tx_o       = tx_q;
   assign tx_done_o  = tx_done_q;
   assign byte_cnt_o = byte_cnt_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed-plus-random bench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT and
// every TX frame is compared against the ideal 8N1 waveform built from the byte value.
module tb_fifo_uart_tx;
   localparam int unsigned C = 4;
   localparam int          FrameLen = 10 * C;
   localparam int          Period   = FrameLen + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       tx;
   logic       busy;
   logic       tx_done;
   logic [7:0] byte_cnt;

   fifo_uart_tx_if fif ();

   fifo_uart_tx #(
      .CLKS_PER_BIT(C),
      .CNT_W       (16)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .enable_i  (enable),
      .fifo      (fif),
      .tx_o      (tx),
      .busy_o    (busy),
      .tx_done_o (tx_done),
      .byte_cnt_o(byte_cnt)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         exp_cnt = 0;
   logic [7:0] q[$];
   logic       tx_hist[$];
   int         read_times[$];
   int         done_times[$];
   logic [7:0] done_cnts[$];
   bit         pending = 0;
   bit         busy_seen = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      fif.f_empty_n = 1'b1;
   endtask

   // One clock: model the FIFO pop for a READ seen last cycle, then log the outputs.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (pending) begin
         pending = 0;
         chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) fif.fifo_data = q.pop_front();
         fif.f_empty_n = (q.size() != 0);
      end
      if (fif.read) begin
         pending = 1;
         read_times.push_back(cyc);
      end
      tx_hist.push_back(tx);
      if (busy) busy_seen = 1;
      if (tx_done) begin
         done_times.push_back(cyc);
         done_cnts.push_back(byte_cnt);
      end
   endtask

   task automatic clear_logs();
      read_times.delete();
      done_times.delete();
      done_cnts.delete();
      busy_seen = 0;
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int n = 0;
      while (done_times.size() < target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(done_times.size() >= target), 32'd1);
   endtask

   task automatic wait_read(input string tag, input int budget);
      int n = 0;
      int want = read_times.size() + 1;
      while (read_times.size() < want && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(read_times.size() >= want), 32'd1);
   endtask

   // Ideal frame: start bit 0, data LSB first, stop bit 1, each held C cycles.
   function automatic int frame_errs(input int start, input logic [7:0] b);
      int errs = 0;
      for (int i = 0; i < FrameLen; i++) begin
         int  bitpos = i / C;
         logic want = (bitpos == 0) ? 1'b0 : (bitpos == 9) ? 1'b1 : b[bitpos-1];
         if (start + i >= tx_hist.size() || start + i < 0) errs++;
         else if (tx_hist[start + i] !== want) errs++;
      end
      return errs;
   endfunction

   initial begin
      logic [7:0] rb[5];
      logic [7:0] b1, b2;
      logic [7:0] sent[256];
      int         r, t, errs, gaps;

      fif.f_empty_n = 1'b0;
      fif.fifo_data = 8'h00;
      tx_hist.push_back(1'b1);
      #2 rst = 1'b1;
      repeat (3) tick();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_read", 32'(fif.read), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_cnt", 32'(byte_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // Single byte 0xA5.
      clear_logs();
      push(8'hA5);
      enable = 1'b1;
      wait_done("single_timeout", 1, 100);
      repeat (5) tick();
      exp_cnt++;
      r = read_times[0];
      chk("single_reads", 32'(read_times.size()), 32'd1);
      chk("single_pre_fall", 32'(tx_hist[r+1]), 32'd1);
      chk("single_frame", 32'(frame_errs(r + 2, 8'hA5)), 32'd0);
      chk("single_done_time", 32'(done_times[0]), 32'(r + 2 + FrameLen));
      chk("single_done_pulses", 32'(done_times.size()), 32'd1);
      chk("single_cnt", 32'(byte_cnt), 32'(exp_cnt));

      // Empty FIFO with enable high.
      clear_logs();
      t = cyc;
      repeat (100) tick();
      errs = 0;
      for (int i = t + 1; i <= cyc; i++) if (tx_hist[i] !== 1'b1) errs++;
      chk("empty_reads", 32'(read_times.size()), 32'd0);
      chk("empty_busy", 32'(busy_seen), 32'd0);
      chk("empty_tx_low", 32'(errs), 32'd0);

      // Reset in the middle of the start bit.
      clear_logs();
      push(8'($urandom));
      wait_read("rst_mid_read", 20);
      repeat (3) tick();
      chk("rst_mid_pre_tx", 32'(tx), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_mid_tx", 32'(tx), 32'd1);
      chk("rst_mid_read", 32'(fif.read), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_cnt", 32'(byte_cnt), 32'd0);
      exp_cnt = 0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Back-to-back: 0x00, 0xFF, 0x3C.
      clear_logs();
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      wait_done("b2b_timeout", 3, 3 * Period + 50);
      exp_cnt += 3;
      chk("b2b_reads", 32'(read_times.size()), 32'd3);
      chk("b2b_gap1", 32'(read_times[1] - read_times[0]), 32'(Period));
      chk("b2b_gap2", 32'(read_times[2] - read_times[1]), 32'(Period));
      chk("b2b_f0", 32'(frame_errs(read_times[0] + 2, 8'h00)), 32'd0);
      chk("b2b_f1", 32'(frame_errs(read_times[1] + 2, 8'hFF)), 32'd0);
      chk("b2b_f2", 32'(frame_errs(read_times[2] + 2, 8'h3C)), 32'd0);
      chk("b2b_cnt", 32'(byte_cnt), 32'(exp_cnt));

      // Random bytes back-to-back.
      clear_logs();
      for (int i = 0; i < 5; i++) begin
         rb[i] = 8'($urandom);
         push(rb[i]);
      end
      wait_done("rand_timeout", 5, 5 * Period + 50);
      exp_cnt += 5;
      errs = 0;
      for (int i = 0; i < 5; i++) errs += frame_errs(read_times[i] + 2, rb[i]);
      chk("rand_frames", 32'(errs), 32'd0);
      chk("rand_cnt", 32'(byte_cnt), 32'(exp_cnt));

      // Enable dropped during data bit 3 of the first of two queued bytes.
      enable = 1'b0;
      tick();
      clear_logs();
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      push(b1);
      push(b2);
      enable = 1'b1;
      wait_read("gate_read", 10);
      r = read_times[0];
      while (cyc < r + 2 + 4 * C + 1) tick();
      enable = 1'b0;
      wait_done("gate_timeout", 1, 100);
      repeat (20) tick();
      exp_cnt++;
      chk("gate_reads", 32'(read_times.size()), 32'd1);
      chk("gate_frame1", 32'(frame_errs(r + 2, b1)), 32'd0);
      chk("gate_idle", 32'(busy), 32'd0);
      chk("gate_cnt", 32'(byte_cnt), 32'(exp_cnt));
      t = cyc;
      enable = 1'b1;
      tick();
      chk("gate_restart_reads", 32'(read_times.size()), 32'd2);
      chk("gate_restart_time", 32'(read_times[1]), 32'(t + 1));
      wait_done("gate2_timeout", 2, 100);
      exp_cnt++;
      chk("gate_frame2", 32'(frame_errs(read_times[1] + 2, b2)), 32'd0);
      chk("gate_cnt2", 32'(byte_cnt), 32'(exp_cnt));

      // Counter wrap after 256 frames from reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      exp_cnt = 0;
      clear_logs();
      for (int i = 0; i < 256; i++) begin
         sent[i] = 8'($urandom);
         push(sent[i]);
      end
      wait_done("wrap_timeout", 256, 256 * Period + 100);
      errs = 0;
      gaps = 0;
      for (int i = 0; i < 256; i++) begin
         errs += frame_errs(read_times[i] + 2, sent[i]);
         if (i > 0 && read_times[i] - read_times[i-1] != Period) gaps++;
         if (done_cnts[i] !== 8'((i + 1) % 256)) errs++;
      end
      chk("wrap_frames", 32'(errs), 32'd0);
      chk("wrap_gaps", 32'(gaps), 32'd0);
      chk("wrap_cnt_255", 32'(done_cnts[254]), 32'd255);
      chk("wrap_cnt_0", 32'(done_cnts[255]), 32'd0);
      chk("wrap_cnt_now", 32'(byte_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
